// File: rtl/data_mem_arbiter_if.sv
// Two requesters (CPU load/store, loader/debug) plus the data memory port of the arbiter.
// slave = arbiter side, master = requesters and memory model side.
interface data_mem_arbiter_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
);
   logic                     p0_req;
   logic                     p0_we;
   logic                     p0_adtp;
   logic [ADDRESS_WIDTH-1:0] p0_addr;
   logic [DATA_WIDTH-1:0]    p0_wdata;
   logic                     p0_gnt;
   logic                     p0_done;

   logic                     p1_req;
   logic                     p1_we;
   logic                     p1_adtp;
   logic [ADDRESS_WIDTH-1:0] p1_addr;
   logic [DATA_WIDTH-1:0]    p1_wdata;
   logic                     p1_gnt;
   logic                     p1_done;

   logic [DATA_WIDTH-1:0]    rdata;
   logic                     err;

   logic [ADDRESS_WIDTH-1:0] mem_a;
   logic [DATA_WIDTH-1:0]    mem_wd;
   logic                     mem_we;
   logic                     mem_adtp;
   logic [DATA_WIDTH-1:0]    mem_rd;

   modport slave (
      input  p0_req, p0_we, p0_adtp, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_adtp, p1_addr, p1_wdata,
      output p0_gnt, p0_done, p1_gnt, p1_done,
      output rdata, err,
      output mem_a, mem_wd, mem_we, mem_adtp,
      input  mem_rd
   );

   modport master (
      output p0_req, p0_we, p0_adtp, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_adtp, p1_addr, p1_wdata,
      input  p0_gnt, p0_done, p1_gnt, p1_done,
      input  rdata, err,
      input  mem_a, mem_wd, mem_we, mem_adtp,
      output mem_rd
   );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter of two requesters onto one data memory; optional DMEM_ALIGN_CHECK_EN flags misaligned words.
// Latency: gnt at N, memory access at N+1, done at N+2; one access per 3 cycles.
// Backpressure: requests are only granted in IDLE; requesters hold req until gnt.
module data_mem_arbiter #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   data_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t                   state_q;
   state_t                   state_d;

   // last_q = 1 means port 1 won most recently, so port 0 wins the next tie
   logic                     last_q;
   logic                     id_q;
   logic                     we_q;
   logic                     adtp_q;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    wdata_q;
   logic [DATA_WIDTH-1:0]    rdata_q;

   logic                     gnt0;
   logic                     gnt1;
   logic                     misalign;

`ifdef DMEM_ALIGN_CHECK_EN
   logic                     err_q;
   assign misalign = ~adtp_q & (addr_q[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // Next state and grant; gnt is gated by rst_n so it is low throughout reset.
   always_comb begin
      state_d = state_q;
      gnt0    = 1'b0;
      gnt1    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rst_n && (bus.p0_req || bus.p1_req)) begin
               if (bus.p0_req && (!bus.p1_req || last_q)) begin
                  gnt0 = 1'b1;
               end else begin
                  gnt1 = 1'b1;
               end
               state_d = ACCESS;
            end
         end
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Memory port is only live in ACCESS; reset forces IDLE so mem_we drops asynchronously.
   always_comb begin
      bus.mem_a    = '0;
      bus.mem_wd   = '0;
      bus.mem_adtp = 1'b0;
      bus.mem_we   = 1'b0;
      if (state_q == ACCESS) begin
         bus.mem_a    = addr_q;
         bus.mem_wd   = wdata_q;
         bus.mem_adtp = adtp_q;
         bus.mem_we   = we_q & ~misalign;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         we_q    <= 1'b0;
         adtp_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (gnt0 || gnt1) begin
         last_q  <= gnt1;
         id_q    <= gnt1;
         we_q    <= gnt1 ? bus.p1_we    : bus.p0_we;
         adtp_q  <= gnt1 ? bus.p1_adtp  : bus.p0_adtp;
         addr_q  <= gnt1 ? bus.p1_addr  : bus.p0_addr;
         wdata_q <= gnt1 ? bus.p1_wdata : bus.p0_wdata;
      end
   end

   // Read data is captured for writes too, giving the pre-write content.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (state_q == ACCESS) begin
         rdata_q <= misalign ? '0 : bus.mem_rd;
      end
   end

`ifdef DMEM_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (state_q == ACCESS) begin
         err_q <= misalign;
      end
   end
   assign bus.err = (state_q == RESP) & err_q;
`else
   assign bus.err = 1'b0;
`endif

   assign bus.p0_gnt  = gnt0;
   assign bus.p1_gnt  = gnt1;
   assign bus.p0_done = (state_q == RESP) & ~id_q;
   assign bus.p1_done = (state_q == RESP) &  id_q;
   assign bus.rdata   = rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, giving the width of all address ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, giving the width of all data ports.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports p0_req / p1_req, input, 1 bit each: access request; requester 0 is CPU load/store, requester 1 is loader/debug.
REQ-006 SHALL have ports p0_we / p1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 SHALL have ports p0_adtp / p1_adtp, input, 1 bit each: 0 = 32-bit word access, 1 = byte access zero-extended.
REQ-008 SHALL have ports p0_addr / p1_addr, input, ADDRESS_WIDTH each: byte address.
REQ-009 SHALL have ports p0_wdata / p1_wdata, input, DATA_WIDTH each: write data.
REQ-010 SHALL have ports p0_gnt / p1_gnt, output, 1 bit each: request accepted this cycle.
REQ-011 SHALL have ports p0_done / p1_done, output, 1 bit each: one-cycle completion pulse.
REQ-012 SHALL have port rdata, output, DATA_WIDTH: read data, valid while a done pulse is high.
REQ-013 SHALL have port err, output, 1 bit: misaligned-access flag, valid while a done pulse is high.
REQ-014 SHALL have ports mem_a (ADDRESS_WIDTH), mem_wd (DATA_WIDTH), mem_we (1), mem_adtp (1), all outputs: drive the data memory.
REQ-015 SHALL have port mem_rd, input, DATA_WIDTH: combinational read data returned by the data memory.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCESS and RESP.
REQ-017 In IDLE with any request high, SHALL assert exactly one combinational gnt, latch the winner's we/adtp/addr/wdata/id at the clock edge, and go to ACCESS.
REQ-018 With both requests high, SHALL grant round-robin: the port not granted last wins; a single requester always wins.
REQ-019 In ACCESS, SHALL drive mem_a/mem_wd/mem_adtp from the latched request, assert mem_we only if the latched we=1, capture mem_rd into rdata, and go to RESP.
REQ-020 In RESP, SHALL pulse done for the latched id for one cycle, hold rdata, and return to IDLE.
REQ-021 Latency SHALL be fixed: gnt in cycle N, memory access in N+1, done in N+2; maximum throughput is one access per 3 cycles.
REQ-022 Outside ACCESS, SHALL hold mem_we=0 and mem_a/mem_wd/mem_adtp at 0.
REQ-023 Requests arriving in ACCESS or RESP SHALL be ignored (gnt=0); requesters hold req until gnt.
REQ-024 For write accesses, rdata SHALL equal the value captured from mem_rd, i.e. the pre-write memory content.
REQ-025 done and gnt SHALL never be asserted for both ports in the same cycle.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, round-robin pointer so that port 0 wins the first tie, all gnt/done/err 0, rdata 0, mem_we 0, mem_* 0.
REQ-027 On reset mid-ACCESS, SHALL commit no write (mem_we drops asynchronously) and emit no done after release.
REQ-028 After rst_n rises, SHALL accept requests from the first clock edge.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN defined: a word access (adtp=0) with addr[1:0]!=0 SHALL keep mem_we=0 in ACCESS, return rdata=0, and raise err with its done pulse.
REQ-030 Macro DMEM_ALIGN_CHECK_EN undefined: misaligned accesses SHALL pass through unchanged and err SHALL be tied to 0.

Verification
REQ-031 Single write: p0 word write addr 0x00010000, wdata 0xDEADBEEF -> p0_gnt at N, mem_we=1 at N+1 only, p0_done at N+2; a subsequent word read returns rdata 0xDEADBEEF.
REQ-032 Byte read: memory holds 0xDEADBEEF at 0x00010000; p1 byte read at 0x00010001 -> p1_done at N+2 with rdata 0x000000BE.
REQ-033 Contention: p0_req and p1_req held high for 12 cycles after reset -> grants alternate p0, p1, p0, p1 at cycles 0, 3, 6, 9.
REQ-034 Reset in ACCESS: rst_n low during ACCESS of a p0 write of 0x12345678 -> memory unchanged, no p0_done, gnt 0.
REQ-035 Alignment: word write at 0x00010002 -> with DMEM_ALIGN_CHECK_EN, err=1 and memory unchanged; without it, err=0 and the write occurs.
